// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the streaming expression checker.
package expr_pkg;

    typedef enum logic [1:0] {
        S_OPND  = 2'd0,
        S_NUM   = 2'd1,
        S_CLOSE = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        C_DIGIT = 3'd0,
        C_OP    = 3'd1,
        C_LP    = 3'd2,
        C_RP    = 3'd3,
        C_SP    = 3'd4,
        C_OTHER = 3'd5
    } cls_e;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_LP    = 8'h28;
    localparam logic [7:0] ASC_RP    = 8'h29;
    localparam logic [7:0] ASC_SP    = 8'h20;

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= ASC_0) && (ch <= ASC_9);
    endfunction

endpackage

// File: rtl/expr_stream_checker_char_class.sv
// Combinational ASCII character classifier; '-' and '/' are operators only when enabled.
module expr_char_class
    import expr_pkg::*;
#(
    parameter bit ALLOW_SUB_DIV = 1'b1
) (
    input  logic [7:0] in,
    output cls_e       cls
);

    logic sub_div_s;

    assign sub_div_s = ALLOW_SUB_DIV && ((in == ASC_MINUS) || (in == ASC_SLASH));

    // Map one character onto its grammar class
    always_comb begin
        cls = C_OTHER;
        if (is_digit(in)) begin
            cls = C_DIGIT;
        end else if ((in == ASC_PLUS) || (in == ASC_STAR) || sub_div_s) begin
            cls = C_OP;
        end else if (in == ASC_LP) begin
            cls = C_LP;
        end else if (in == ASC_RP) begin
            cls = C_RP;
        end else if (in == ASC_SP) begin
            cls = C_SP;
        end else begin
            cls = C_OTHER;
        end
    end

endmodule

// File: rtl/expr_stream_checker.sv
// Streaming recognizer for expr := term (op term)*, term := number | '(' expr ')'.
// Outputs are registered and describe the prefix consumed up to the last edge.
module expr_stream_checker
    import expr_pkg::*;
#(
    parameter int  MAX_DIGITS    = 4,
    parameter int  MAX_DEPTH     = 7,
    parameter bit  ALLOW_SUB_DIV = 1'b1,
    localparam int DEPTH_W       = $clog2(MAX_DEPTH + 1),
    localparam int DIG_W         = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               sync_clr,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [DIG_W-1:0]   digits
);

    cls_e               cls_s;
    state_e             state_r, state_nx_s;
    logic [DEPTH_W-1:0] depth_r, depth_nx_s;
    logic [DIG_W-1:0]   digits_r, digits_nx_s;
    logic               out_r, out_nx_s;
    logic               err_r, err_nx_s;
    logic               depth_room_s, depth_open_s;

    expr_char_class #(
        .ALLOW_SUB_DIV (ALLOW_SUB_DIV)
    ) u_class (
        .in  (in),
        .cls (cls_s)
    );

    assign depth_room_s = (depth_r < DEPTH_W'(MAX_DEPTH));
    assign depth_open_s = (depth_r != {DEPTH_W{1'b0}});

    // Next-state and counter updates; overflow/underflow goes to S_ERR before any counter moves
    always_comb begin
        state_nx_s  = state_r;
        depth_nx_s  = depth_r;
        digits_nx_s = digits_r;
        case (state_r)
            S_OPND: begin
                case (cls_s)
                    C_DIGIT: begin
                        state_nx_s  = S_NUM;
                        digits_nx_s = DIG_W'(1);
                    end
                    C_LP: begin
                        if (depth_room_s) begin
                            depth_nx_s = depth_r + DEPTH_W'(1);
                        end else begin
                            state_nx_s = S_ERR;
                        end
                    end
                    C_SP:    state_nx_s = state_r;
                    default: state_nx_s = S_ERR;
                endcase
            end
            S_NUM: begin
                case (cls_s)
                    C_DIGIT: begin
                        if (digits_r < DIG_W'(MAX_DIGITS)) begin
                            digits_nx_s = digits_r + DIG_W'(1);
                        end else begin
                            state_nx_s = S_ERR;
                        end
                    end
                    C_OP: begin
                        state_nx_s  = S_OPND;
                        digits_nx_s = {DIG_W{1'b0}};
                    end
                    C_RP: begin
                        if (depth_open_s) begin
                            state_nx_s  = S_CLOSE;
                            depth_nx_s  = depth_r - DEPTH_W'(1);
                            digits_nx_s = {DIG_W{1'b0}};
                        end else begin
                            state_nx_s = S_ERR;
                        end
                    end
                    C_SP:    state_nx_s = state_r;
                    default: state_nx_s = S_ERR;
                endcase
            end
            S_CLOSE: begin
                case (cls_s)
                    C_OP: state_nx_s = S_OPND;
                    C_RP: begin
                        if (depth_open_s) begin
                            depth_nx_s = depth_r - DEPTH_W'(1);
                        end else begin
                            state_nx_s = S_ERR;
                        end
                    end
                    C_SP:    state_nx_s = state_r;
                    default: state_nx_s = S_ERR;
                endcase
            end
            S_ERR:   state_nx_s = S_ERR;
            default: state_nx_s = S_ERR;
        endcase
        if (state_nx_s == S_ERR) begin
            digits_nx_s = {DIG_W{1'b0}};
        end else begin
            digits_nx_s = digits_nx_s;
        end
    end

    // Output values as they will be after this character is consumed
    always_comb begin
        err_nx_s = (state_nx_s == S_ERR);
        out_nx_s = ((state_nx_s == S_NUM) || (state_nx_s == S_CLOSE)) &&
                   (depth_nx_s == {DEPTH_W{1'b0}});
    end

    // State and output registers; sync_clr outranks a character in the same cycle
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r  <= S_OPND;
            depth_r  <= {DEPTH_W{1'b0}};
            digits_r <= {DIG_W{1'b0}};
            out_r    <= 1'b0;
            err_r    <= 1'b0;
        end else if (sync_clr) begin
            state_r  <= S_OPND;
            depth_r  <= {DEPTH_W{1'b0}};
            digits_r <= {DIG_W{1'b0}};
            out_r    <= 1'b0;
            err_r    <= 1'b0;
        end else if (in_valid) begin
            state_r  <= state_nx_s;
            depth_r  <= depth_nx_s;
            digits_r <= digits_nx_s;
            out_r    <= out_nx_s;
            err_r    <= err_nx_s;
        end else begin
            state_r  <= state_r;
            depth_r  <= depth_r;
            digits_r <= digits_r;
            out_r    <= out_r;
            err_r    <= err_r;
        end
    end

    assign out    = out_r;
    assign err    = err_r;
    assign depth  = depth_r;
    assign digits = digits_r;

endmodule
